// File: rtl/quad_port_ram_pkg.sv
// Shared constants and types for the four-port 512x16 data/instruction store.
package quad_port_ram_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 9;
  localparam int DEPTH      = 512;
  localparam int NUM_PORTS  = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/qpr_read_port.sv
// One registered read port: captures the addressed word on read_en, holds otherwise,
// and clears to zero while rst_n is low.
module qpr_read_port #(
  parameter int DATA_WIDTH = quad_port_ram_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data_out
);

  import quad_port_ram_pkg::*;

  logic [DATA_WIDTH-1:0] data_r;

  // Read data register: synchronous clear, load on enable, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (read_en) begin
      data_r <= rd_word;
    end else begin
      data_r <= data_r;
    end
  end

  assign data_out = data_r;

endmodule

// File: rtl/quad_port_ram.sv
// 512x16 RAM with four symmetric synchronous read/write ports; reads are read-first
// and simultaneous writes to one address resolve in favour of the highest port.
module quad_port_ram #(
  parameter int DATA_WIDTH = quad_port_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = quad_port_ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = quad_port_ram_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en1,
  input  logic                  read_en1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] Data_in1,
  output logic [DATA_WIDTH-1:0] Data_out1,
  input  logic                  write_en2,
  input  logic                  read_en2,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] Data_in2,
  output logic [DATA_WIDTH-1:0] Data_out2,
  input  logic                  write_en3,
  input  logic                  read_en3,
  input  logic [ADDR_WIDTH-1:0] addr3,
  input  logic [DATA_WIDTH-1:0] Data_in3,
  output logic [DATA_WIDTH-1:0] Data_out3,
  input  logic                  write_en4,
  input  logic                  read_en4,
  input  logic [ADDR_WIDTH-1:0] addr4,
  input  logic [DATA_WIDTH-1:0] Data_in4,
  output logic [DATA_WIDTH-1:0] Data_out4
);

  import quad_port_ram_pkg::*;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [NUM_PORTS-1:0]  we_s;
  logic [NUM_PORTS-1:0]  re_s;
  logic [ADDR_WIDTH-1:0] addr_s    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_s   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata_s   [NUM_PORTS];

  assign we_s = {write_en4, write_en3, write_en2, write_en1};
  assign re_s = {read_en4, read_en3, read_en2, read_en1};

  assign addr_s[0] = addr1;
  assign addr_s[1] = addr2;
  assign addr_s[2] = addr3;
  assign addr_s[3] = addr4;

  assign wdata_s[0] = Data_in1;
  assign wdata_s[1] = Data_in2;
  assign wdata_s[2] = Data_in3;
  assign wdata_s[3] = Data_in4;

  // Storage write: ports applied in ascending order so the last (highest) port wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (we_s[p]) begin
          mem_r[addr_s[p]] <= wdata_s[p];
        end
      end
    end
  end

  // The array is sampled before this edge's writes land, giving read-first behaviour.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    qpr_read_port #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .read_en  (re_s[g]),
      .rd_word  (mem_r[addr_s[g]]),
      .data_out (rdata_s[g])
    );
  end

  assign Data_out1 = rdata_s[0];
  assign Data_out2 = rdata_s[1];
  assign Data_out3 = rdata_s[2];
  assign Data_out4 = rdata_s[3];

endmodule

// File: tb/tb_quad_port_ram.sv
// Self-checking bench for quad_port_ram: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural memory model.
module tb_quad_port_ram;

  logic        clk;
  logic        rst_n;
  logic        we   [4];
  logic        re   [4];
  logic [8:0]  addr [4];
  logic [15:0] din  [4];
  logic [15:0] dout [4];

  int errors = 0;
  int checks = 0;

  // Behavioural model: memory contents with written flags, plus expected outputs.
  logic [15:0] m_mem    [512];
  bit          m_ok     [512];
  logic [15:0] m_out    [4];
  bit          m_out_ok [4];

  quad_port_ram dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_en1 (we[0]), .read_en1 (re[0]), .addr1 (addr[0]), .Data_in1 (din[0]), .Data_out1 (dout[0]),
    .write_en2 (we[1]), .read_en2 (re[1]), .addr2 (addr[1]), .Data_in2 (din[1]), .Data_out2 (dout[1]),
    .write_en3 (we[2]), .read_en3 (re[2]), .addr3 (addr[2]), .Data_in3 (din[2]), .Data_out3 (dout[2]),
    .write_en4 (we[3]), .read_en4 (re[3]), .addr4 (addr[3]), .Data_in4 (din[3]), .Data_out4 (dout[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 512; i++) m_ok[i] = 1'b0;
    for (int p = 0; p < 4; p++) m_out_ok[p] = 1'b0;
  end

  // Model update: reads see pre-edge contents; writes in port order so port 4 wins.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) begin
        m_out[p]    <= 16'd0;
        m_out_ok[p] <= 1'b1;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (re[p]) begin
          m_out[p]    <= m_mem[addr[p]];
          m_out_ok[p] <= m_ok[addr[p]];
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (we[p]) begin
          m_mem[addr[p]] <= din[p];
          m_ok[addr[p]]  <= 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every port whose expected value is defined.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (m_out_ok[p]) begin
        checks++;
        if (dout[p] !== m_out[p]) begin
          errors++;
          $display("FAIL model_port%0d t=%0t got=%0d exp=%0d", p + 1, $time, dout[p], m_out[p]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    for (int p = 0; p < 4; p++) begin
      we[p] = 1'b0;
      re[p] = 1'b0;
    end
  endtask

  task automatic wr(input int p, input int a, input int d);
    we[p]   = 1'b1;
    addr[p] = 9'(a);
    din[p]  = 16'(d);
  endtask

  task automatic rd(input int p, input int a);
    re[p]   = 1'b1;
    addr[p] = 9'(a);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 4; p++) begin
      we[p] = 1'b0; re[p] = 1'b0; addr[p] = 9'd0; din[p] = 16'd0;
    end
    tick();
    tick();
    for (int p = 0; p < 4; p++) chk($sformatf("reset_out%0d", p + 1), dout[p], 16'd0);
    rst_n = 1'b1;

    // Parallel write then read.
    idle(); wr(0, 1, 1); wr(1, 4, 7); wr(2, 7, 15); wr(3, 10, 70); tick();
    idle(); rd(0, 1); rd(1, 4); rd(2, 7); rd(3, 10); tick();
    chk("par_out1", dout[0], 16'd1);
    chk("par_out2", dout[1], 16'd7);
    chk("par_out3", dout[2], 16'd15);
    chk("par_out4", dout[3], 16'd70);

    // Cross-port visibility.
    idle(); wr(0, 2, 4); wr(1, 5, 9); tick();
    idle(); rd(2, 2); rd(3, 5); tick();
    chk("cross_out3", dout[2], 16'd4);
    chk("cross_out4", dout[3], 16'd9);

    // Read-first on the same address across ports.
    idle(); wr(0, 3, 8); tick();
    idle(); wr(0, 3, 99); rd(1, 3); tick();
    chk("rdfirst_old", dout[1], 16'd8);
    idle(); rd(1, 3); tick();
    chk("rdfirst_new", dout[1], 16'd99);

    // Write collision: port 4 wins, then hold with read_en low.
    idle(); wr(0, 12, 30); wr(1, 12, 31); wr(2, 12, 32); wr(3, 12, 33); tick();
    idle(); rd(0, 12); tick();
    chk("collide_rd", dout[0], 16'd33);
    idle(); addr[0] = 9'd1; tick();
    chk("collide_hold", dout[0], 16'd33);

    // Hold on port 3 with a changed address.
    idle(); wr(2, 9, 65); wr(1, 8, 123); tick();
    idle(); rd(2, 9); tick();
    chk("hold_rd", dout[2], 16'd65);
    idle(); addr[2] = 9'd8; tick(); tick();
    chk("hold_keep", dout[2], 16'd65);

    // Reset with nonzero outputs and a concurrent write that must be ignored.
    idle(); rd(0, 4); rd(1, 7); rd(3, 10); tick();
    rst_n = 1'b0; idle(); wr(0, 1, 5); tick();
    for (int p = 0; p < 4; p++) chk($sformatf("rst_out%0d", p + 1), dout[p], 16'd0);
    rst_n = 1'b1; idle(); rd(0, 1); tick();
    chk("rst_mem_kept", dout[0], 16'd1);

    // Full-range address corners.
    idle(); wr(0, 0, 16'h1234); wr(1, 511, 16'hBEEF); tick();
    idle(); rd(2, 0); rd(3, 511); tick();
    chk("addr_lo", dout[2], 16'h1234);
    chk("addr_hi", dout[3], 16'hBEEF);

    // Randomized traffic, concentrated on a few addresses to force collisions.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 4; p++) begin
        we[p]   = $urandom_range(0, 1) == 1;
        re[p]   = $urandom_range(0, 1) == 1;
        addr[p] = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
        din[p]  = 16'($urandom);
      end
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
